// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
// Purpose : FSM state encoding, forwarding-select encodings, counter widths and
//           a saturating-increment helper used by hazard_ctrl and fwd_unit.
// Ports   : none (package)
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  localparam int REG_W  = 4;
  localparam int CNT_W  = 16;
  localparam int WAIT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// rtl/hazard_ctrl_fwd.sv - per-source operand forwarding select
// Purpose : chooses where one ID-stage source operand comes from.
// Ports   : src       - source register number being read
//           fwd_en    - forwarding enabled
//           mem_wb_en, mem_dest - writer currently in MEM
//           wb_en, wb_dest      - writer currently in WB
//           sel       - SEL_MEM / SEL_WB / SEL_RF
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             fwd_en,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_dest,
  output logic [1:0]       sel
);

  // MEM holds the younger result, so it takes precedence over WB.
  always_comb begin
    sel = SEL_RF;
    if (fwd_en && mem_wb_en && (mem_dest == src)) begin
      sel = SEL_MEM;
    end else if (fwd_en && wb_en && (wb_dest == src)) begin
      sel = SEL_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, branch flush, memory-wait and forwarding control
// Purpose : freezes/flushes pipeline stages for memory waits, load-use hazards and
//           taken branches; selects forwarding paths; counts stalls and flushes.
// Ports   : clk, rst (async, active-low)
//           id_*      - ID-stage sources / validity
//           exe_*, mem_*, wb_* - downstream writers
//           fwd_en, b_taken, mem_req, mem_ready - controls
//           freeze_all, freeze_if, flush_if, flush_id - pipeline control outputs
//           sel_src1, sel_src2 - forwarding selects
//           mem_err   - sticky memory timeout flag
//           stall_cnt, flush_cnt - saturating event counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_en,
  input  logic             fwd_en,
  input  logic             b_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_all,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic       mem_busy;
  logic       exe_hit, mem_hit;
  logic       load_use, hazard;
  logic [1:0] sel1_raw, sel2_raw;

  assign mem_busy = mem_req & ~mem_ready;

  // A source only matches src2 when the instruction actually reads src2.
  assign exe_hit = (exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2));
  assign mem_hit = (mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2));

  // A load result is never forwardable in time; without forwarding any
  // pending EXE/MEM write to a source must also wait.
  assign load_use = exe_mem_r_en & exe_wb_en & exe_hit;
  assign hazard   = id_valid & (load_use |
                    (~fwd_en & ((exe_wb_en & exe_hit) | (mem_wb_en & mem_hit))));

  fwd_unit u_fwd_src1 (
    .src       (id_src1),
    .fwd_en    (fwd_en),
    .mem_wb_en (mem_wb_en),
    .mem_dest  (mem_dest),
    .wb_en     (wb_en),
    .wb_dest   (wb_dest),
    .sel       (sel1_raw)
  );

  fwd_unit u_fwd_src2 (
    .src       (id_src2),
    .fwd_en    (fwd_en),
    .mem_wb_en (mem_wb_en),
    .mem_dest  (mem_dest),
    .wb_en     (wb_en),
    .wb_dest   (wb_dest),
    .sel       (sel2_raw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= sat_inc(stall_q, freeze_if | freeze_all);
      flush_q <= sat_inc(flush_q, flush_if);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    freeze_all = 1'b0;
    freeze_if  = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;

    // The first busy cycle freezes immediately, before the state change lands.
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          freeze_all = 1'b1;
          wait_d     = WAIT_W'(1);
          state_d    = (TIMEOUT <= 1) ? ST_ERROR : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          freeze_all = 1'b1;
          wait_d     = wait_q + WAIT_W'(1);
          if (wait_d == TIMEOUT_W) begin
            state_d = ST_ERROR;
          end
        end else begin
          wait_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_ERROR: begin
        freeze_all = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase

    // A taken branch discards the ID instruction anyway, so it needs no stall.
    if (!freeze_all) begin
      if (b_taken) begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (hazard) begin
        freeze_if = 1'b1;
        flush_id  = 1'b1;
      end
    end

    // Outputs are quiet while reset is held, independent of the inputs.
    if (!rst) begin
      freeze_all = 1'b0;
      freeze_if  = 1'b0;
      flush_if   = 1'b0;
      flush_id   = 1'b0;
    end
  end

  assign sel_src1  = rst ? sel1_raw : SEL_RF;
  assign sel_src2  = rst ? sel2_raw : SEL_RF;
  assign mem_err   = (state_q == ST_ERROR);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of consecutive memory-busy cycles after which the error state is entered.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 SHALL have input ports id_src1 and id_src2, 4 bits each, and id_two_src, 1 bit: the ID-stage source registers and a flag meaning src2 is used.
REQ-005 SHALL have input port id_valid, 1 bit, meaning the ID stage holds a real instruction.
REQ-006 SHALL have input ports exe_dest (4 bits), exe_wb_en and exe_mem_r_en (1 bit each): destination and controls of the instruction in EXE.
REQ-007 SHALL have input ports mem_dest (4 bits) and mem_wb_en (1 bit), plus wb_dest (4 bits) and wb_en (1 bit).
REQ-008 SHALL have input port fwd_en, 1 bit, which enables forwarding.
REQ-009 SHALL have input port b_taken, 1 bit: the branch in EXE is taken.
REQ-010 SHALL have input ports mem_req and mem_ready, 1 bit each: the memory-stage handshake.
REQ-011 SHALL have output ports freeze_all (all pipeline registers and PC hold) and freeze_if (PC and IF/ID hold), 1 bit each.
REQ-012 SHALL have output ports flush_if (IF/ID becomes a bubble) and flush_id (ID/EXE becomes a bubble), 1 bit each.
REQ-013 SHALL have output ports sel_src1 and sel_src2, 2 bits each, encoded 00 register file, 01 MEM-stage ALU result, 10 WB value.
REQ-014 SHALL have output port mem_err, 1 bit, sticky.
REQ-015 SHALL have output ports stall_cnt and flush_cnt, 16 bits each, saturating.

Function
REQ-016 SHALL implement an FSM with states RUN, MEM_WAIT and ERROR.
REQ-017 SHALL define mem_busy = mem_req & ~mem_ready.
REQ-018 SHALL, in RUN with mem_busy, go to MEM_WAIT, load the wait counter with 1, and assert freeze_all combinationally in the same cycle.
REQ-019 SHALL, in MEM_WAIT, assert freeze_all while mem_busy, increment the wait counter each cycle, and return to RUN in the cycle mem_ready=1 (freeze_all=0 in that cycle).
REQ-020 SHALL, when the wait counter reaches TIMEOUT in MEM_WAIT, go to ERROR.
REQ-021 SHALL, in ERROR, hold freeze_all=1 and mem_err=1 until reset; all other inputs are ignored.
REQ-022 SHALL define a load-use hazard as id_valid & exe_mem_r_en & exe_wb_en & (exe_dest==id_src1 | (id_two_src & exe_dest==id_src2)).
REQ-023 SHALL, with fwd_en=0, also treat an exe_wb_en or mem_wb_en match on the sources as a hazard.
REQ-024 SHALL, on a hazard without freeze_all, assert freeze_if=1 and flush_id=1 for that cycle (one bubble per cycle the hazard persists).
REQ-025 SHALL, on b_taken without freeze_all, assert flush_if=1 and flush_id=1; freeze_if SHALL be 0 (branch overrides a simultaneous hazard).
REQ-026 SHALL apply priority freeze_all > branch > hazard, and SHALL drive flush and freeze_if to 0 while freeze_all=1.
REQ-027 SHALL compute forwarding combinationally per source: 01 if fwd_en & mem_wb_en & mem_dest==src; else 10 if fwd_en & wb_en & wb_dest==src; else 00. MEM SHALL win over WB.
REQ-028 SHALL increment stall_cnt each cycle freeze_if or freeze_all is 1, and flush_cnt each cycle flush_if is 1; both SHALL saturate at 16'hFFFF.

Reset
REQ-029 SHALL, while rst=0 and regardless of clk, set state RUN, wait counter 0, mem_err 0 and both counters 0.
REQ-030 SHALL, while rst=0, drive freeze_all=0, freeze_if=0, flush_if=0, flush_id=0 and sel_src*=00.
REQ-031 SHALL abandon any MEM_WAIT or ERROR when reset is asserted mid-operation.

Structure
REQ-032 SHALL place the state encoding, the sel encodings (SEL_RF, SEL_MEM, SEL_WB) and the counter widths in a shared package, hazard_pkg.
REQ-033 SHALL contain one sub-module, fwd_unit, holding the combinational forwarding logic; it is instantiated once per source.

Verification
REQ-034 SHALL cover: EXE load with exe_dest=3, ID src1=3 -> freeze_if=1, flush_id=1 for 1 cycle; stall_cnt 0->1.
REQ-035 SHALL cover: b_taken=1 together with a load-use hazard -> flush_if=1, flush_id=1, freeze_if=0; flush_cnt 0->1.
REQ-036 SHALL cover: mem_req=1, mem_ready=0 for 4 cycles, then 1 -> freeze_all=1 for exactly 4 cycles, and state is RUN after.
REQ-037 SHALL cover: TIMEOUT=8 with mem_ready held at 0 -> ERROR after 8 busy cycles, mem_err=1 stays set; rst pulse -> mem_err=0, state RUN.
REQ-038 SHALL cover: fwd_en=1, mem_dest=wb_dest=5, both wb enables set, src2=5 -> sel_src2=01; with fwd_en=0 -> sel_src2=00 and stall.
REQ-039 SHALL cover: stall_cnt preloaded to 16'hFFFE, 3 stall cycles -> stall_cnt holds at 16'hFFFF.
